// File: rtl/boot_seq_ctrl.sv
// Boot sequencer: settle delay, APB write of the core boot address, start
// condition per boot mode, then supervision of the run until EOC or timeout.
module boot_seq_ctrl #(
  parameter int unsigned DELAY_CYCLES   = 16,
  parameter logic [31:0] BOOT_ADDR_REG  = 32'h1A10_7008,
  parameter logic [31:0] BOOT_ADDR      = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter int unsigned TIMEOUT_W      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  boot_mode_i,
  input  logic        fetch_enable_i,
  input  logic        load_done_i,
  input  logic        eoc_i,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  output logic        pwrite_o,
  output logic        psel_o,
  output logic        penable_o,
  input  logic        pready_i,
  input  logic        pslverr_i,
  output logic        fetch_enable_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  err_code_o,
  output logic [2:0]  state_o
);

  localparam logic [2:0] ST_SETTLE = 3'd0;
  localparam logic [2:0] ST_SETUP  = 3'd1;
  localparam logic [2:0] ST_ACCESS = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;
  localparam logic [2:0] ST_DONE   = 3'd5;
  localparam logic [2:0] ST_ERROR  = 3'd6;

  localparam int unsigned DLY = (DELAY_CYCLES == 0) ? 1 : DELAY_CYCLES;
  localparam int unsigned CW  = (DLY > 1) ? $clog2(DLY) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DLY - 1);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST =
    TIMEOUT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           mode_q, mode_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [1:0]           err_q, err_d;
  // {eoc, load_done, fetch_enable} through two flops each
  logic [2:0]           sync1_q, sync2_q;

  logic fe_s, ld_s, eoc_s, apb_act;

  assign fe_s  = sync2_q[0];
  assign ld_s  = sync2_q[1];
  assign eoc_s = sync2_q[2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      state_q <= ST_SETTLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      tmo_q   <= '0;
      err_q   <= '0;
    end else begin
      sync1_q <= {eoc_i, load_done_i, fetch_enable_i};
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    case (state_q)
      ST_SETTLE: begin
        if (cnt_q == CNT_LAST) begin
          mode_d  = boot_mode_i;
          state_d = boot_mode_i[1] ? ST_WAIT : ST_SETUP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready_i) begin
          if (pslverr_i) begin
            state_d = ST_ERROR;
            err_d   = 2'b01;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (mode_q[1] || (mode_q == 2'b00 && fe_s) || (mode_q == 2'b01 && ld_s))
          state_d = ST_RUN;
      end
      ST_RUN: begin
        tmo_d = tmo_q + TIMEOUT_W'(1);
        // EOC has priority over a timeout landing in the same cycle
        if (eoc_s) begin
          state_d = ST_DONE;
        end else if (TIMEOUT_CYCLES != 0 && tmo_q == TMO_LAST) begin
          state_d = ST_ERROR;
          err_d   = 2'b10;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Outputs decode state only so reset clears them without waiting for a clock
  assign apb_act        = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign psel_o         = apb_act;
  assign penable_o      = (state_q == ST_ACCESS);
  assign pwrite_o       = apb_act;
  assign paddr_o        = apb_act ? BOOT_ADDR_REG : 32'h0;
  assign pwdata_o       = apb_act ? BOOT_ADDR : 32'h0;
  assign fetch_enable_o = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign busy_o         = !((state_q == ST_DONE) || (state_q == ST_ERROR));
  assign done_o         = (state_q == ST_DONE);
  assign error_o        = (state_q == ST_ERROR);
  assign err_code_o     = err_q;
  assign state_o        = state_q;

endmodule
